// File: rtl/morse_key_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | morse_key_classifier                                                     |
// | Synchronises and debounces a raw Morse key, then classifies each press   |
// | as dot/dash and reports letter boundaries from the release length.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module morse_key_classifier #(
  parameter int DEB_CYCLES = 4,
  parameter int DASH_MIN   = 20,
  parameter int GAP_CYCLES = 40,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic       shift,
  output logic       SI,
  output logic [2:0] sym_count,
  output logic       letter_done,
  output logic       overflow
);

  localparam int               DEB_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       MAX_SYM    = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Synchroniser
  logic sync1_q;
  logic key_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      sync1_q <= key_in;
      key_s_q <= sync1_q;
    end
  end

  // Debouncer: the level flips on the DEB_CYCLES-th consecutive differing sample
  logic             key_db_q,  key_db_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    key_db_d  = key_db_q;
    deb_cnt_d = '0;
    if (key_s_q != key_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        key_db_d = key_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_db_q  <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      key_db_q  <= key_db_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Press/gap classifier
  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic [CNT_W-1:0] gap_q,   gap_d;
  logic             shift_q, shift_d;
  logic             si_q,    si_d;
  logic             done_q,  done_d;
  logic [2:0]       cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    gap_d   = gap_q;
    shift_d = 1'b0;
    si_d    = si_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    // Count and overflow stay visible for the letter_done cycle, then clear
    if (done_q) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (key_db_q) begin
          state_d = S_PRESS;
          len_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_PRESS: begin
        if (key_db_q) begin
          len_d = sat_inc(len_q);
        end else begin
          if (cnt_q < MAX_SYM) begin
            shift_d = 1'b1;
            si_d    = (len_q >= DASH_MIN_C);
            cnt_d   = cnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = S_GAP;
          gap_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        if (key_db_q) begin
          state_d = S_PRESS;
          len_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (gap_q >= GAP_LAST) begin
          done_d  = 1'b1;
          si_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = sat_inc(gap_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      shift_q <= 1'b0;
      si_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      si_q    <= si_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign shift       = shift_q;
  assign SI          = si_q;
  assign sym_count   = cnt_q;
  assign letter_done = done_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_key_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_morse_key_classifier                                                  |
// | Directed scenarios for the Morse key front-end.                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_morse_key_classifier;

  logic       clk;
  logic       reset;
  logic       key_in;
  logic       shift;
  logic       SI;
  logic [2:0] sym_count;
  logic       letter_done;
  logic       overflow;

  int   tests;
  int   fails;
  int   shift_cnt;
  int   ld_cnt;
  int   ld_sym;
  int   ld_ovf;
  int   si_idx;
  logic si_hist [16];

  morse_key_classifier #(
    .DEB_CYCLES(4),
    .DASH_MIN  (20),
    .GAP_CYCLES(40),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .shift      (shift),
    .SI         (SI),
    .sym_count  (sym_count),
    .letter_done(letter_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and log strobes seen just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (shift) begin
      if (si_idx < 16) si_hist[si_idx] = SI;
      si_idx++;
      shift_cnt++;
    end
    if (letter_done) begin
      ld_cnt++;
      ld_sym = int'(sym_count);
      ld_ovf = int'(overflow);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int n);
    key_in = 1'b1;
    idle(n);
    key_in = 1'b0;
  endtask

  task automatic clear_log();
    shift_cnt = 0;
    ld_cnt    = 0;
    ld_sym    = -1;
    ld_ovf    = -1;
    si_idx    = 0;
    for (int i = 0; i < 16; i++) si_hist[i] = 1'bx;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    key_in = 1'b0;
    clear_log();
    idle(3);
    tests++;
    if ({shift, SI, sym_count, letter_done, overflow} !== 7'b0) begin
      fails++;
      $display("FAIL reset_values: got %b required 0000000", {shift, SI, sym_count, letter_done, overflow});
    end
    reset = 1'b0;
    press(5); idle(10);
    press(5); idle(10);
    tests++;
    if (sym_count !== 3'd2) begin
      fails++;
      $display("FAIL reset_pre_count: got %0d required 2", sym_count);
    end
    key_in = 1'b1;
    idle(15);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({shift, SI, sym_count, letter_done, overflow} !== 7'b0) begin
      fails++;
      $display("FAIL reset_async: got %b required 0000000", {shift, SI, sym_count, letter_done, overflow});
    end
    clear_log();
    idle(3);
    reset = 1'b0;
    idle(25);
    tests++;
    if (shift_cnt != 0 || ld_cnt != 0) begin
      fails++;
      $display("FAIL reset_no_strobe: got shifts=%0d done=%0d required 0 0", shift_cnt, ld_cnt);
    end
    key_in = 1'b0;
    idle(8);
    tests++;
    if (shift_cnt != 1 || si_hist[0] !== 1'b1 || sym_count !== 3'd1) begin
      fails++;
      $display("FAIL reset_new_press: got shifts=%0d SI=%b count=%0d required 1 1 1", shift_cnt, si_hist[0], sym_count);
    end
    idle(40);
    tests++;
    if (ld_cnt != 1 || ld_sym != 1) begin
      fails++;
      $display("FAIL reset_letter: got done=%0d count=%0d required 1 1", ld_cnt, ld_sym);
    end
    idle(5);
  endtask

  task automatic test_dash_boundary();
    clear_log();
    press(19); idle(10);
    press(20); idle(8);
    tests++;
    if (shift_cnt != 2 || si_hist[0] !== 1'b0 || si_hist[1] !== 1'b1 || sym_count !== 3'd2) begin
      fails++;
      $display("FAIL dash_boundary: got shifts=%0d SI=%b%b count=%0d required 2 01 2", shift_cnt, si_hist[0], si_hist[1], sym_count);
    end
    idle(50);
  endtask

  task automatic test_letter_k();
    clear_log();
    press(30); idle(10);
    press(8);  idle(10);
    press(30);
    idle(45);
    tests++;
    if (shift_cnt != 3 || si_hist[0] !== 1'b1 || si_hist[1] !== 1'b0 || si_hist[2] !== 1'b1) begin
      fails++;
      $display("FAIL k_symbols: got shifts=%0d SI=%b%b%b required 3 101", shift_cnt, si_hist[0], si_hist[1], si_hist[2]);
    end
    tests++;
    if (ld_cnt != 0) begin
      fails++;
      $display("FAIL k_early_done: got done=%0d required 0", ld_cnt);
    end
    tick();
    tests++;
    if (letter_done !== 1'b1 || sym_count !== 3'd3) begin
      fails++;
      $display("FAIL k_done: got done=%b count=%0d required 1 3", letter_done, sym_count);
    end
    tick();
    tests++;
    if (letter_done !== 1'b0 || sym_count !== 3'd0) begin
      fails++;
      $display("FAIL k_clear: got done=%b count=%0d required 0 0", letter_done, sym_count);
    end
    idle(5);
  endtask

  task automatic test_bounce();
    clear_log();
    for (int i = 0; i < 3; i++) begin
      key_in = 1'b1;
      idle(3);
      key_in = 1'b0;
      idle(10);
    end
    idle(50);
    tests++;
    if (shift_cnt != 0 || ld_cnt != 0) begin
      fails++;
      $display("FAIL bounce_reject: got shifts=%0d done=%0d required 0 0", shift_cnt, ld_cnt);
    end
    press(4);
    idle(8);
    tests++;
    if (shift_cnt != 1 || si_hist[0] !== 1'b0) begin
      fails++;
      $display("FAIL bounce_accept: got shifts=%0d SI=%b required 1 0", shift_cnt, si_hist[0]);
    end
    idle(45);
    tests++;
    if (ld_cnt != 1 || ld_sym != 1) begin
      fails++;
      $display("FAIL bounce_letter: got done=%0d count=%0d required 1 1", ld_cnt, ld_sym);
    end
  endtask

  task automatic test_overflow();
    clear_log();
    for (int i = 0; i < 5; i++) begin
      press(5);
      idle(10);
    end
    press(5);
    idle(8);
    tests++;
    if (shift_cnt != 5 || overflow !== 1'b1 || sym_count !== 3'd5) begin
      fails++;
      $display("FAIL ovf_set: got shifts=%0d ovf=%b count=%0d required 5 1 5", shift_cnt, overflow, sym_count);
    end
    idle(38);
    tests++;
    if (letter_done !== 1'b1 || sym_count !== 3'd5 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_done: got done=%b count=%0d ovf=%b required 1 5 1", letter_done, sym_count, overflow);
    end
    tick();
    tests++;
    if (sym_count !== 3'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got count=%0d ovf=%b required 0 0", sym_count, overflow);
    end
    idle(5);
  endtask

  task automatic test_gap_boundary();
    clear_log();
    press(5); idle(39);
    press(5); idle(39);
    press(5); idle(8);
    tests++;
    if (ld_cnt != 0 || sym_count !== 3'd3) begin
      fails++;
      $display("FAIL gap39_continue: got done=%0d count=%0d required 0 3", ld_cnt, sym_count);
    end
    idle(38);
    tests++;
    if (ld_cnt != 1 || ld_sym != 3) begin
      fails++;
      $display("FAIL gap39_letter: got done=%0d count=%0d required 1 3", ld_cnt, ld_sym);
    end
    idle(5);
    clear_log();
    press(5); idle(40);
    press(5); idle(8);
    tests++;
    if (ld_cnt != 1 || ld_sym != 1 || sym_count !== 3'd1 || shift_cnt != 2) begin
      fails++;
      $display("FAIL gap40_split: got done=%0d prev=%0d count=%0d shifts=%0d required 1 1 1 2", ld_cnt, ld_sym, sym_count, shift_cnt);
    end
    idle(50);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    key_in = 1'b0;
    test_reset();
    test_dash_boundary();
    test_letter_k();
    test_bounce();
    test_overflow();
    test_gap_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
